// File: rtl/cfar_pkg.sv
// rtl/cfar_pkg.sv - shared CFAR constants, width helpers and noise-mode enumeration
// Contents:
//   cfar_mode_e    noise estimator selection (cell averaging or greatest-of)
//   ALPHA_W        width of the unsigned Q4.4 threshold factor
//   cfar_win_len   samples held in the sliding window
//   cfar_sum_w     width of one exact reference-cell sum
//   cfar_thr_w     width of the applied threshold
package cfar_pkg;

  typedef enum logic {
    CFAR_MODE_CA = 1'b0,
    CFAR_MODE_GO = 1'b1
  } cfar_mode_e;

  localparam int ALPHA_W = 8;

  function automatic int cfar_win_len(input int ref_n, input int guard_n);
    return 2 * (ref_n + guard_n) + 1;
  endfunction

  // REF_N is a power of two, so REF_N samples of data_w bits fit exactly.
  function automatic int cfar_sum_w(input int data_w, input int ref_n);
    return data_w + $clog2(ref_n);
  endfunction

  function automatic int cfar_thr_w(input int data_w, input int ref_n);
    return data_w + $clog2(2 * ref_n) + ALPHA_W;
  endfunction

endpackage

// File: rtl/cfar_window.sv
// rtl/cfar_window.sv - sliding sample window with incrementally maintained lead/lag sums
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   shift_i                accept data_i into the window
//   clear_i                with shift_i: drop old content, data_i becomes the only sample
//   data_i                 incoming sample
//   cut_o                  cell under test (centre of the window)
//   lead_sum_o, lag_sum_o  sums of the older / newer reference cells
module cfar_window
  import cfar_pkg::*;
#(
  parameter int DATA_W  = 49,
  parameter int REF_N   = 8,
  parameter int GUARD_N = 2,
  localparam int SUM_W  = cfar_sum_w(DATA_W, REF_N)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              shift_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] cut_o,
  output logic [SUM_W-1:0]  lead_sum_o,
  output logic [SUM_W-1:0]  lag_sum_o
);

  localparam int W = cfar_win_len(REF_N, GUARD_N);
  localparam int C = REF_N + GUARD_N;

  // win_q[0] is the newest sample. Lag cells are indices 0..REF_N-1,
  // lead cells W-REF_N..W-1, the CUT sits at index C.
  logic [DATA_W-1:0] win_q [W];
  logic [DATA_W-1:0] win_d [W];
  logic [SUM_W-1:0]  lead_q, lead_d, lag_q, lag_d;

  always_comb begin
    win_d  = win_q;
    lead_d = lead_q;
    lag_d  = lag_q;
    if (shift_i) begin
      win_d[0] = data_i;
      if (clear_i) begin
        for (int i = 1; i < W; i++) win_d[i] = '0;
        lag_d  = SUM_W'(data_i);
        lead_d = '0;
      end else begin
        for (int i = 1; i < W; i++) win_d[i] = win_q[i-1];
        // Modular add/subtract is exact because the true sum always fits SUM_W.
        lag_d  = lag_q + SUM_W'(data_i) - SUM_W'(win_q[REF_N-1]);
        lead_d = lead_q + SUM_W'(win_q[W-REF_N-1]) - SUM_W'(win_q[W-1]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < W; i++) win_q[i] <= '0;
      lead_q <= '0;
      lag_q  <= '0;
    end else begin
      win_q  <= win_d;
      lead_q <= lead_d;
      lag_q  <= lag_d;
    end
  end

  assign cut_o      = win_q[C];
  assign lead_sum_o = lead_q;
  assign lag_sum_o  = lag_q;

endmodule

// File: rtl/cfar_detector.sv
// rtl/cfar_detector.sv - CFAR detector over a streamed range sweep, 3-stage pipeline
// Build macro: CFAR_GO_EN selects greatest-of noise (2*max of sums); default is cell averaging.
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   in_valid, in_sop, in_data     sample stream; in_sop only counts with in_valid
//   det_valid                     one-cycle pulse per interior cell under test
//   det_flag, det_bin, det_level  detection, range index and CUT value
//   det_thresh                    threshold applied to that CUT
module cfar_detector
  import cfar_pkg::*;
#(
  parameter int DATA_W   = 49,
  parameter int N_BINS   = 512,
  parameter int REF_N    = 8,
  parameter int GUARD_N  = 2,
  parameter int ALPHA_Q4 = 48
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  input  logic                                 in_sop,
  input  logic [DATA_W-1:0]                    in_data,
  output logic                                 det_valid,
  output logic                                 det_flag,
  output logic [$clog2(N_BINS)-1:0]            det_bin,
  output logic [DATA_W-1:0]                    det_level,
  output logic [cfar_thr_w(DATA_W, REF_N)-1:0] det_thresh
);

  localparam int BIN_W   = $clog2(N_BINS);
  localparam int W       = cfar_win_len(REF_N, GUARD_N);
  localparam int C       = REF_N + GUARD_N;
  localparam int SUM_W   = cfar_sum_w(DATA_W, REF_N);
  localparam int NOISE_W = SUM_W + 1;
  localparam int THR_W   = cfar_thr_w(DATA_W, REF_N);
  localparam int PROD_W  = NOISE_W + ALPHA_W;
  localparam int SHIFT   = 4 + $clog2(2 * REF_N);
`ifdef CFAR_GO_EN
  localparam cfar_mode_e MODE = CFAR_MODE_GO;
`else
  localparam cfar_mode_e MODE = CFAR_MODE_CA;
`endif

  // Stage 1: bin counter and window. The bin counter restarts on every sop
  // (explicit or wrap), so it also tells how many samples the window holds.
  logic [BIN_W-1:0]  bin_q, bin_d, cur_bin;
  logic              restart;
  logic              s1_valid_q, s1_valid_d;
  logic [BIN_W-1:0]  s1_bin_q, s1_bin_d;
  logic [DATA_W-1:0] cut;
  logic [SUM_W-1:0]  lead_sum, lag_sum;

  always_comb begin
    cur_bin    = in_sop ? '0 : bin_q;
    restart    = in_valid && (cur_bin == '0);
    bin_d      = bin_q;
    if (in_valid) bin_d = (cur_bin == BIN_W'(N_BINS - 1)) ? '0 : cur_bin + 1'b1;
    // The window is full once bin W-1 arrives; the CUT then lags by C bins.
    s1_valid_d = in_valid && (cur_bin >= BIN_W'(W - 1));
    s1_bin_d   = cur_bin - BIN_W'(C);
  end

  cfar_window #(
    .DATA_W  (DATA_W),
    .REF_N   (REF_N),
    .GUARD_N (GUARD_N)
  ) u_window (
    .clk_i      (clk),
    .rst_ni     (rst),
    .shift_i    (in_valid),
    .clear_i    (restart),
    .data_i     (in_data),
    .cut_o      (cut),
    .lead_sum_o (lead_sum),
    .lag_sum_o  (lag_sum)
  );

  // Stage 2: noise estimate and threshold multiply.
  logic [NOISE_W-1:0] noise;
  logic [PROD_W-1:0]  prod;
  logic               s2_valid_q;
  logic [BIN_W-1:0]   s2_bin_q;
  logic [DATA_W-1:0]  s2_level_q;
  logic [THR_W-1:0]   s2_thr_q;

  always_comb begin
    noise = NOISE_W'(lead_sum) + NOISE_W'(lag_sum);
    if (MODE == CFAR_MODE_GO) noise = (lead_sum >= lag_sum) ? {lead_sum, 1'b0} : {lag_sum, 1'b0};
    prod = PROD_W'(noise) * PROD_W'(ALPHA_W'(ALPHA_Q4));
  end

  // Stage 3: strict compare; payload is forced to zero outside det_valid.
  logic              det_valid_q, det_flag_q, det_flag_d;
  logic [BIN_W-1:0]  det_bin_q;
  logic [DATA_W-1:0] det_level_q;
  logic [THR_W-1:0]  det_thresh_q;

  assign det_flag_d = s2_valid_q && (THR_W'(s2_level_q) > s2_thr_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      bin_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_bin_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_bin_q     <= '0;
      s2_level_q   <= '0;
      s2_thr_q     <= '0;
      det_valid_q  <= 1'b0;
      det_flag_q   <= 1'b0;
      det_bin_q    <= '0;
      det_level_q  <= '0;
      det_thresh_q <= '0;
    end else begin
      bin_q        <= bin_d;
      s1_valid_q   <= s1_valid_d;
      s1_bin_q     <= s1_bin_d;
      s2_valid_q   <= s1_valid_q;
      s2_bin_q     <= s1_bin_q;
      s2_level_q   <= cut;
      s2_thr_q     <= THR_W'(prod >> SHIFT);
      det_valid_q  <= s2_valid_q;
      det_flag_q   <= det_flag_d;
      det_bin_q    <= s2_valid_q ? s2_bin_q : '0;
      det_level_q  <= s2_valid_q ? s2_level_q : '0;
      det_thresh_q <= s2_valid_q ? s2_thr_q : '0;
    end
  end

  assign det_valid  = det_valid_q;
  assign det_flag   = det_flag_q;
  assign det_bin    = det_bin_q;
  assign det_level  = det_level_q;
  assign det_thresh = det_thresh_q;

endmodule

// File: tb/tb_cfar_detector.sv
// tb/tb_cfar_detector.sv - self-checking bench for cfar_detector against a sweep-level reference model
module tb_cfar_detector;

  localparam int DATA_W   = 49;
  localparam int N_BINS   = 512;
  localparam int REF_N    = 8;
  localparam int GUARD_N  = 2;
  localparam int ALPHA_Q4 = 48;
  localparam int C        = REF_N + GUARD_N;
  localparam int BIN_W    = $clog2(N_BINS);
  localparam int THR_W    = DATA_W + $clog2(2 * REF_N) + 8;
  localparam int SHIFT    = 4 + $clog2(2 * REF_N);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_sop = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              det_valid, det_flag;
  logic [BIN_W-1:0]  det_bin;
  logic [DATA_W-1:0] det_level;
  logic [THR_W-1:0]  det_thresh;

  typedef struct {
    int              bin;
    bit              flag;
    longint unsigned level;
    longint unsigned thresh;
    int              cyc;
  } res_t;

  res_t            mon_q[$];
  res_t            exp_q[$];
  longint unsigned seg_data[$];
  int              seg_cyc[$];
  int              cyc = 0;
  int              n_checks = 0;
  int              n_fail = 0;

  cfar_detector #(
    .DATA_W   (DATA_W),
    .N_BINS   (N_BINS),
    .REF_N    (REF_N),
    .GUARD_N  (GUARD_N),
    .ALPHA_Q4 (ALPHA_Q4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .in_data    (in_data),
    .det_valid  (det_valid),
    .det_flag   (det_flag),
    .det_bin    (det_bin),
    .det_level  (det_level),
    .det_thresh (det_thresh)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    res_t r;
    if (det_valid) begin
      r.bin = int'(det_bin);
      r.flag = det_flag;
      r.level = 64'(det_level);
      r.thresh = 64'(det_thresh);
      r.cyc = cyc;
      mon_q.push_back(r);
    end
  end

  function automatic string fmt(input res_t r);
    return $sformatf("bin=%0d flag=%0d level=%0d thr=%0d cyc=%0d", r.bin, r.flag, r.level, r.thresh, r.cyc);
  endfunction

  // Result for sweep-relative CUT index k, straight from the detection rule.
  function automatic res_t model_cut(input int k);
    longint unsigned lead = 0, lag = 0, noise;
    res_t r;
    for (int j = 1; j <= REF_N; j++) begin
      lead += seg_data[k-GUARD_N-j];
      lag  += seg_data[k+GUARD_N+j];
    end
`ifdef CFAR_GO_EN
    noise = 2 * ((lead > lag) ? lead : lag);
`else
    noise = lead + lag;
`endif
    r.bin = k;
    r.level = seg_data[k];
    r.thresh = (noise * 64'(ALPHA_Q4)) >> SHIFT;
    r.flag = r.level > r.thresh;
    r.cyc = seg_cyc[k+C] + 3;
    return r;
  endfunction

  function automatic longint unsigned rand_val();
    longint unsigned v;
    if ($urandom_range(0, 9) == 0) v = {$urandom, $urandom};
    else v = 64'($urandom_range(0, 2000));
    return v & ((64'd1 << DATA_W) - 1);
  endfunction

  task automatic drive(input longint unsigned d, input bit sop, input int gap);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sop = 1'($urandom_range(0, 1));
      in_data = DATA_W'({$urandom, $urandom});
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_sop = sop;
    in_data = DATA_W'(d);
    if (sop || seg_data.size() == N_BINS) begin
      seg_data.delete();
      seg_cyc.delete();
    end
    seg_data.push_back(d);
    seg_cyc.push_back(cyc);
    if (seg_data.size() >= 2 * C + 1) exp_q.push_back(model_cut(seg_data.size() - 1 - C));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sop = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (det_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", det_valid); end
    n_checks++; if (det_flag !== 1'b0) begin n_fail++; $display("FAIL reset_flag: got %b want 0", det_flag); end
    n_checks++; if (det_bin !== '0) begin n_fail++; $display("FAIL reset_bin: got %0d want 0", det_bin); end
    n_checks++; if (det_level !== '0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", det_level); end
    n_checks++; if (det_thresh !== '0) begin n_fail++; $display("FAIL reset_thresh: got %0d want 0", det_thresh); end
    rst = 1'b1;
  endtask

  task automatic test_single_target();
    int nflag = 0, fbin = -1;
    longint unsigned thr100 = 0;
    mon_q.delete(); exp_q.delete();
    for (int b = 0; b < N_BINS; b++) drive((b == 100) ? 64'd1000 : 64'd100, b == 0, 0);
    idle(6);
    n_checks++;
    if (mon_q.size() != exp_q.size()) begin n_fail++; $display("FAIL target_count: got %0d want %0d", mon_q.size(), exp_q.size()); end
    for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (fmt(mon_q[i]) != fmt(exp_q[i])) begin n_fail++; $display("FAIL target_result: got %s want %s", fmt(mon_q[i]), fmt(exp_q[i])); end
    end
    foreach (mon_q[i]) begin
      if (mon_q[i].flag) begin nflag++; fbin = mon_q[i].bin; end
      if (mon_q[i].bin == 100) thr100 = mon_q[i].thresh;
    end
    n_checks++; if (nflag != 1) begin n_fail++; $display("FAIL target_nflag: got %0d want 1", nflag); end
    n_checks++; if (fbin != 100) begin n_fail++; $display("FAIL target_bin: got %0d want 100", fbin); end
    n_checks++; if (thr100 != 300) begin n_fail++; $display("FAIL target_thresh: got %0d want 300", thr100); end
  endtask

  task automatic test_strict_compare();
    for (int v = 300; v <= 301; v++) begin
      int flag100 = -1;
      longint unsigned thr100 = 0;
      mon_q.delete(); exp_q.delete();
      for (int b = 0; b < N_BINS; b++) drive((b == 100) ? 64'(v) : 64'd100, b == 0, 0);
      idle(6);
      foreach (mon_q[i]) if (mon_q[i].bin == 100) begin flag100 = int'(mon_q[i].flag); thr100 = mon_q[i].thresh; end
      n_checks++;
      if (flag100 != ((v == 301) ? 1 : 0)) begin n_fail++; $display("FAIL strict_flag_%0d: got %0d want %0d", v, flag100, (v == 301) ? 1 : 0); end
      n_checks++; if (thr100 != 300) begin n_fail++; $display("FAIL strict_thresh_%0d: got %0d want 300", v, thr100); end
    end
  endtask

  task automatic test_sweep_edges();
    int c21;
    mon_q.delete(); exp_q.delete();
    for (int b = 0; b < N_BINS; b++) drive(rand_val(), b == 0, 0);
    c21 = seg_cyc[20];
    idle(6);
    n_checks++;
    if (mon_q.size() != 492) begin n_fail++; $display("FAIL edges_count: got %0d want 492", mon_q.size()); end
    if (mon_q.size() > 0) begin
      n_checks++; if (mon_q[0].bin != 10) begin n_fail++; $display("FAIL edges_first_bin: got %0d want 10", mon_q[0].bin); end
      n_checks++; if (mon_q[0].cyc != c21 + 3) begin n_fail++; $display("FAIL edges_latency: got cycle %0d want %0d", mon_q[0].cyc, c21 + 3); end
      n_checks++; if (mon_q[$].bin != 501) begin n_fail++; $display("FAIL edges_last_bin: got %0d want 501", mon_q[$].bin); end
    end
    for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (fmt(mon_q[i]) != fmt(exp_q[i])) begin n_fail++; $display("FAIL edges_result: got %s want %s", fmt(mon_q[i]), fmt(exp_q[i])); end
    end
  endtask

  task automatic test_mid_sweep_sop();
    int sopc, c21, n_gap = 0;
    mon_q.delete(); exp_q.delete();
    for (int b = 0; b <= 50; b++) drive(64'(5000 + $urandom_range(0, 100)), b == 0, 0);
    for (int b = 0; b < N_BINS; b++) drive(rand_val(), b == 0, 0);
    sopc = seg_cyc[0];
    c21 = seg_cyc[20];
    idle(6);
    foreach (mon_q[i]) if (mon_q[i].cyc > sopc + 2 && mon_q[i].cyc < c21 + 3) n_gap++;
    n_checks++; if (n_gap != 0) begin n_fail++; $display("FAIL midsop_gap: got %0d results want 0", n_gap); end
    n_checks++;
    if (mon_q.size() != exp_q.size()) begin n_fail++; $display("FAIL midsop_count: got %0d want %0d", mon_q.size(), exp_q.size()); end
    for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (fmt(mon_q[i]) != fmt(exp_q[i])) begin n_fail++; $display("FAIL midsop_result: got %s want %s", fmt(mon_q[i]), fmt(exp_q[i])); end
    end
  endtask

  task automatic test_go_mode();
    longint unsigned d, want_thr, thr200 = 0;
    int flag200 = -1;
`ifdef CFAR_GO_EN
    want_thr = 1500;
`else
    want_thr = 900;
`endif
    mon_q.delete(); exp_q.delete();
    for (int b = 0; b < N_BINS; b++) begin
      d = 0;
      if (b >= 190 && b <= 197) d = 500;
      if (b == 200) d = 2000;
      if (b >= 203 && b <= 210) d = 100;
      drive(d, b == 0, 0);
    end
    idle(6);
    foreach (mon_q[i]) if (mon_q[i].bin == 200) begin thr200 = mon_q[i].thresh; flag200 = int'(mon_q[i].flag); end
    n_checks++; if (thr200 != want_thr) begin n_fail++; $display("FAIL mode_thresh: got %0d want %0d", thr200, want_thr); end
    n_checks++; if (flag200 != 1) begin n_fail++; $display("FAIL mode_flag: got %0d want 1", flag200); end
    n_checks++;
    if (mon_q.size() != exp_q.size()) begin n_fail++; $display("FAIL mode_count: got %0d want %0d", mon_q.size(), exp_q.size()); end
    for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (fmt(mon_q[i]) != fmt(exp_q[i])) begin n_fail++; $display("FAIL mode_result: got %s want %s", fmt(mon_q[i]), fmt(exp_q[i])); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int rcyc, n_pre, fbin = -1, nflag = 0;
    mon_q.delete(); exp_q.delete();
    for (int b = 0; b <= 40; b++) drive(64'($urandom_range(0, 1000)), b == 0, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; in_sop = 1'b0; in_data = DATA_W'(777);
    rcyc = cyc + 1;
    while (exp_q.size() > 0 && exp_q[$].cyc >= rcyc) void'(exp_q.pop_back());
    seg_data.delete(); seg_cyc.delete();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    n_checks++;
    if ({det_valid, det_flag, det_bin, det_level, det_thresh} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: got valid=%b flag=%b bin=%0d level=%0d thr=%0d want all 0", det_valid, det_flag, det_bin, det_level, det_thresh);
    end
    n_pre = mon_q.size();
    n_checks++; if (n_pre != 19) begin n_fail++; $display("FAIL rstmid_emitted: got %0d want 19", n_pre); end
    if (n_pre > 0) begin
      n_checks++; if (mon_q[$].bin != 28) begin n_fail++; $display("FAIL rstmid_last_bin: got %0d want 28", mon_q[$].bin); end
    end
    for (int b = 0; b < N_BINS; b++) drive((b == 300) ? 64'd1000 : 64'd100, b == 0, 0);
    idle(6);
    for (int i = n_pre; i < mon_q.size(); i++) if (mon_q[i].flag) begin nflag++; fbin = mon_q[i].bin; end
    n_checks++; if (nflag != 1 || fbin != 300) begin n_fail++; $display("FAIL rstmid_detect: got %0d flags at bin %0d want 1 at 300", nflag, fbin); end
    n_checks++;
    if (mon_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rstmid_count: got %0d want %0d", mon_q.size(), exp_q.size()); end
    for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (fmt(mon_q[i]) != fmt(exp_q[i])) begin n_fail++; $display("FAIL rstmid_result: got %s want %s", fmt(mon_q[i]), fmt(exp_q[i])); end
    end
  endtask

  task automatic test_random_gaps();
    mon_q.delete(); exp_q.delete();
    // One full sweep, then continue without in_sop so the counter wraps.
    for (int b = 0; b < N_BINS + 300; b++)
      drive(rand_val(), b == 0, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    idle(6);
    n_checks++;
    if (mon_q.size() != exp_q.size()) begin n_fail++; $display("FAIL gaps_count: got %0d want %0d", mon_q.size(), exp_q.size()); end
    for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (fmt(mon_q[i]) != fmt(exp_q[i])) begin n_fail++; $display("FAIL gaps_result: got %s want %s", fmt(mon_q[i]), fmt(exp_q[i])); end
    end
  endtask

  initial begin
    test_reset();
    test_single_target();
    test_strict_compare();
    test_sweep_edges();
    test_mid_sweep_sop();
    test_go_mode();
    test_reset_mid_sweep();
    test_random_gaps();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
